// File: rtl/cpu_io_pass_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_io_pass_ctrl
//
// Operand/result pass block between the CPU and the fabric switch matrix.
// Operand channels carry CPU data into the fabric and result channels carry
// fabric data back. Each channel is either a plain wire or a register. A small
// valid/ready controller gives a fixed, configurable compute latency between
// accepting an operand set and presenting the result.
//
// Ports:
//   UserCLK     - fabric user clock (only clock)
//   UserRSTn    - asynchronous active-low reset
//   ConfigBits  - static config {HS_EN, LAT, RES_REG[NUM_RES-1:0], OP_REG[NUM_OP-1:0]}
//   op_data     - CPU operand bus, channel i at [i*WIDTH +: WIDTH]
//   op_valid    - CPU offers operands
//   op_ready    - block accepts operands
//   OP_O        - operands into the switch matrix
//   RES_I       - results from the switch matrix
//   RES_O       - results to the CPU
//   res_valid   - result available
//   res_ready   - CPU takes result
//   busy        - transaction in flight
//   txn_count   - completed-transaction counter (wraps)
// ---------------------------------------------------------------------------
module cpu_io_pass_ctrl #(
  parameter int WIDTH        = 4,
  parameter int NUM_OP       = 2,
  parameter int NUM_RES      = 3,
  parameter int LAT_BITS     = 4,
  parameter int CNT_W        = 8,
  parameter int NoConfigBits = NUM_OP + NUM_RES + LAT_BITS + 1
) (
  input  logic                       UserCLK,
  input  logic                       UserRSTn,
  input  logic [NoConfigBits-1:0]    ConfigBits,
  input  logic [NUM_OP*WIDTH-1:0]    op_data,
  input  logic                       op_valid,
  output logic                       op_ready,
  output logic [NUM_OP*WIDTH-1:0]    OP_O,
  input  logic [NUM_RES*WIDTH-1:0]   RES_I,
  output logic [NUM_RES*WIDTH-1:0]   RES_O,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       busy,
  output logic [CNT_W-1:0]           txn_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Configuration field decode
  logic [NUM_OP-1:0]   w_opRegSel;
  logic [NUM_RES-1:0]  w_resRegSel;
  logic [LAT_BITS-1:0] w_lat;
  logic                w_hsEn;

  assign w_opRegSel  = ConfigBits[NUM_OP-1:0];
  assign w_resRegSel = ConfigBits[NUM_OP +: NUM_RES];
  assign w_lat       = ConfigBits[NUM_OP+NUM_RES +: LAT_BITS];
  assign w_hsEn      = ConfigBits[NoConfigBits-1];

  state_t                r_state;
  state_t                w_stateNext;
  logic [LAT_BITS-1:0]   r_latCnt;
  logic [LAT_BITS-1:0]   w_latCntNext;
  logic                  r_active;
  logic [NUM_OP*WIDTH-1:0]  r_opReg;
  logic [NUM_RES*WIDTH-1:0] r_resReg;
  logic [CNT_W-1:0]      r_txnCount;

  logic w_accept;
  logic w_capture;
  logic w_complete;
  logic w_opLoad;
  logic w_resLoad;
  logic w_opReady;

  // r_active holds op_ready low through reset and until the first clock edge
  // after release, so a release between edges never opens the handshake early.
  always_ff @(posedge UserCLK or negedge UserRSTn) begin
    if (!UserRSTn) begin
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
    end
  end

  // Without handshaking the block is a free-running pass stage and always ready.
  assign w_opReady = r_active && (!w_hsEn || (r_state == IDLE));

  // Next-state logic. Clearing HS_EN abandons any transaction on the next edge.
  always_comb begin
    w_stateNext  = r_state;
    w_latCntNext = r_latCnt;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_complete   = 1'b0;
    if (!w_hsEn) begin
      w_stateNext  = IDLE;
      w_latCntNext = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (op_valid && w_opReady) begin
            w_accept     = 1'b1;
            w_latCntNext = w_lat;
            w_stateNext  = WAIT;
          end
        end
        WAIT: begin
          if (r_latCnt != '0) begin
            w_latCntNext = r_latCnt - {{(LAT_BITS-1){1'b0}}, 1'b1};
          end else begin
            w_capture   = 1'b1;
            w_stateNext = DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            w_complete  = 1'b1;
            w_stateNext = IDLE;
          end
        end
        default: begin
          w_stateNext = IDLE;
        end
      endcase
    end
  end

  // State and latency counter registers
  always_ff @(posedge UserCLK or negedge UserRSTn) begin
    if (!UserRSTn) begin
      r_state  <= IDLE;
      r_latCnt <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_latCnt <= w_latCntNext;
    end
  end

  // Completed-transaction counter; abandoned transactions never reach DONE
  // handshake so they are not counted.
  always_ff @(posedge UserCLK or negedge UserRSTn) begin
    if (!UserRSTn) begin
      r_txnCount <= '0;
    end else if (w_complete) begin
      r_txnCount <= r_txnCount + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // All channel registers load together; the per-channel select decides
  // whether the register or the wire reaches the output, so toggling a
  // select never disturbs stored contents.
  assign w_opLoad  = w_hsEn ? w_accept  : 1'b1;
  assign w_resLoad = w_hsEn ? w_capture : 1'b1;

  always_ff @(posedge UserCLK or negedge UserRSTn) begin
    if (!UserRSTn) begin
      r_opReg <= '0;
    end else if (w_opLoad) begin
      r_opReg <= op_data;
    end
  end

  always_ff @(posedge UserCLK or negedge UserRSTn) begin
    if (!UserRSTn) begin
      r_resReg <= '0;
    end else if (w_resLoad) begin
      r_resReg <= RES_I;
    end
  end

  // Per-channel output select
  for (genvar i = 0; i < NUM_OP; i++) begin : g_opCh
    assign OP_O[i*WIDTH +: WIDTH] = w_opRegSel[i] ? r_opReg[i*WIDTH +: WIDTH]
                                                   : op_data[i*WIDTH +: WIDTH];
  end

  for (genvar j = 0; j < NUM_RES; j++) begin : g_resCh
    assign RES_O[j*WIDTH +: WIDTH] = w_resRegSel[j] ? r_resReg[j*WIDTH +: WIDTH]
                                                     : RES_I[j*WIDTH +: WIDTH];
  end

  assign op_ready  = w_opReady;
  assign res_valid = w_hsEn && (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign txn_count = r_txnCount;

endmodule

// File: tb/tb_cpu_io_pass_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_io_pass_ctrl
//
// Directed bench for cpu_io_pass_ctrl with default parameters
// (WIDTH=4, NUM_OP=2, NUM_RES=3, LAT_BITS=4, CNT_W=8, 10 config bits).
// "Cycle k" below means the clock period that follows active edge k-1.
// ---------------------------------------------------------------------------
module tb_cpu_io_pass_ctrl;

  logic        clk;
  logic        rstN;
  logic [9:0]  cfg;
  logic [7:0]  opData;
  logic        opValid;
  logic        opReady;
  logic [7:0]  opO;
  logic [11:0] resI;
  logic [11:0] resO;
  logic        resValid;
  logic        resReady;
  logic        busy;
  logic [7:0]  txnCount;

  int vectorCount;
  int missCount;
  logic [7:0] expTxn;

  cpu_io_pass_ctrl dut (
    .UserCLK    (clk),
    .UserRSTn   (rstN),
    .ConfigBits (cfg),
    .op_data    (opData),
    .op_valid   (opValid),
    .op_ready   (opReady),
    .OP_O       (opO),
    .RES_I      (resI),
    .RES_O      (resO),
    .res_valid  (resValid),
    .res_ready  (resReady),
    .busy       (busy),
    .txn_count  (txnCount)
  );

  // 10 ns clock, active edges at multiples of 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Config word: {HS_EN, LAT[3:0], RES_REG[2:0], OP_REG[1:0]}
  function automatic logic [9:0] mkCfg(input logic hs, input logic [3:0] lat,
                                       input logic [2:0] resReg, input logic [1:0] opReg);
    return {hs, lat, resReg, opReg};
  endfunction

  // Drive all inputs, then let combinational paths settle
  task automatic applyStimulus(input logic [9:0] c, input logic [7:0] od, input logic ov,
                               input logic [11:0] ri, input logic rr);
    cfg      = c;
    opData   = od;
    opValid  = ov;
    resI     = ri;
    resReady = rr;
    #1;
  endtask

  // Advance past one active edge and sample 1 ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectorCount++;
    assert (observed === expected)
    else begin
      missCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    vectorCount = 0;
    missCount   = 0;
    $display("[TB] start");

    // ---------------- reset state ----------------
    rstN = 1'b0;
    applyStimulus(mkCfg(1'b1, 4'd3, 3'b111, 2'b11), 8'h00, 1'b0, 12'h000, 1'b0);
    checkOutput("rst_opReady",  {15'd0, opReady},  16'h0);
    checkOutput("rst_resValid", {15'd0, resValid}, 16'h0);
    checkOutput("rst_busy",     {15'd0, busy},     16'h0);
    checkOutput("rst_txn",      {8'd0, txnCount},  16'h0);
    checkOutput("rst_opO",      {8'd0, opO},       16'h0);
    checkOutput("rst_resO",     {4'd0, resO},      16'h0);
    step();
    step();
    checkOutput("rst_hold_opReady", {15'd0, opReady}, 16'h0);
    rstN = 1'b1;
    step();
    checkOutput("rel_opReady", {15'd0, opReady}, 16'h1);
    checkOutput("rel_busy",    {15'd0, busy},    16'h0);

    // ---------------- HS_EN=1, LAT=3, all registered ----------------
    applyStimulus(mkCfg(1'b1, 4'd3, 3'b111, 2'b11), 8'h5A, 1'b1, 12'h123, 1'b0);
    checkOutput("l3_idle_ready", {15'd0, opReady}, 16'h1);
    step();                                                  // cycle 1
    applyStimulus(mkCfg(1'b1, 4'd3, 3'b111, 2'b11), 8'h00, 1'b0, 12'h123, 1'b0);
    checkOutput("l3_c1_opReady", {15'd0, opReady}, 16'h0);
    checkOutput("l3_c1_busy",    {15'd0, busy},    16'h1);
    checkOutput("l3_c1_opO",     {8'd0, opO},      16'h005A);
    step();                                                  // cycle 2
    step();                                                  // cycle 3
    step();                                                  // cycle 4
    checkOutput("l3_c4_opReady",  {15'd0, opReady},  16'h0);
    checkOutput("l3_c4_resValid", {15'd0, resValid}, 16'h0);
    step();                                                  // cycle 5
    checkOutput("l3_c5_resValid", {15'd0, resValid}, 16'h1);
    checkOutput("l3_c5_resO",     {4'd0, resO},      16'h0123);
    checkOutput("l3_c5_opO",      {8'd0, opO},       16'h005A);
    checkOutput("l3_c5_opReady",  {15'd0, opReady},  16'h0);
    step();                                                  // cycle 6
    step();                                                  // cycle 7
    applyStimulus(mkCfg(1'b1, 4'd3, 3'b111, 2'b11), 8'h00, 1'b0, 12'h123, 1'b1);
    step();                                                  // cycle 8
    applyStimulus(mkCfg(1'b1, 4'd3, 3'b111, 2'b11), 8'h00, 1'b0, 12'h123, 1'b0);
    checkOutput("l3_c8_txn",      {8'd0, txnCount},  16'h1);
    checkOutput("l3_c8_opReady",  {15'd0, opReady},  16'h1);
    checkOutput("l3_c8_resValid", {15'd0, resValid}, 16'h0);
    checkOutput("l3_c8_busy",     {15'd0, busy},     16'h0);

    // ---------------- result channel 1 combinational ----------------
    applyStimulus(mkCfg(1'b1, 4'd1, 3'b101, 2'b11), 8'h5A, 1'b1, 12'h123, 1'b0);
    step();                                                  // cycle 1
    applyStimulus(mkCfg(1'b1, 4'd1, 3'b101, 2'b11), 8'h5A, 1'b0, 12'h123, 1'b0);
    step();                                                  // cycle 2
    checkOutput("mix_c2_resValid", {15'd0, resValid}, 16'h0);
    step();                                                  // cycle 3, DONE
    checkOutput("mix_c3_resValid", {15'd0, resValid}, 16'h1);
    checkOutput("mix_c3_resO",     {4'd0, resO},      16'h0123);
    applyStimulus(mkCfg(1'b1, 4'd1, 3'b101, 2'b11), 8'h5A, 1'b0, 12'h789, 1'b0);
    checkOutput("mix_follow_resO", {4'd0, resO},      16'h0183);
    checkOutput("mix_opO",         {8'd0, opO},       16'h005A);
    applyStimulus(mkCfg(1'b1, 4'd1, 3'b101, 2'b11), 8'h5A, 1'b0, 12'h789, 1'b1);
    step();
    applyStimulus(mkCfg(1'b1, 4'd1, 3'b101, 2'b11), 8'h5A, 1'b0, 12'h789, 1'b0);
    checkOutput("mix_txn", {8'd0, txnCount}, 16'h2);

    // ---------------- HS_EN cleared in DONE ----------------
    applyStimulus(mkCfg(1'b1, 4'd0, 3'b111, 2'b11), 8'h5A, 1'b1, 12'h456, 1'b0);
    step();                                                  // WAIT
    applyStimulus(mkCfg(1'b1, 4'd0, 3'b111, 2'b11), 8'h5A, 1'b0, 12'h456, 1'b0);
    step();                                                  // DONE
    checkOutput("hs_done_resValid", {15'd0, resValid}, 16'h1);
    checkOutput("hs_done_resO",     {4'd0, resO},      16'h0456);
    applyStimulus(mkCfg(1'b0, 4'd0, 3'b111, 2'b11), 8'h33, 1'b0, 12'hABC, 1'b0);
    checkOutput("hs_off_opReady", {15'd0, opReady}, 16'h1);
    step();
    checkOutput("hs_off_resValid", {15'd0, resValid}, 16'h0);
    checkOutput("hs_off_busy",     {15'd0, busy},     16'h0);
    checkOutput("hs_off_txn",      {8'd0, txnCount},  16'h2);
    checkOutput("hs_off_resO",     {4'd0, resO},      16'h0ABC);
    checkOutput("hs_off_opO",      {8'd0, opO},       16'h0033);
    applyStimulus(mkCfg(1'b0, 4'd0, 3'b111, 2'b11), 8'h77, 1'b0, 12'hDEF, 1'b0);
    step();
    checkOutput("hs_track_resO", {4'd0, resO},     16'h0DEF);
    checkOutput("hs_track_opO",  {8'd0, opO},      16'h0077);
    checkOutput("hs_track_txn",  {8'd0, txnCount}, 16'h2);

    // ---------------- LAT changed during WAIT ----------------
    applyStimulus(mkCfg(1'b1, 4'd2, 3'b111, 2'b11), 8'h5A, 1'b1, 12'h456, 1'b0);
    checkOutput("lat_idle_ready", {15'd0, opReady}, 16'h1);
    step();                                                  // cycle 1
    applyStimulus(mkCfg(1'b1, 4'd9, 3'b111, 2'b11), 8'h5A, 1'b0, 12'h456, 1'b0);
    step();                                                  // cycle 2
    step();                                                  // cycle 3
    checkOutput("lat_c3_resValid", {15'd0, resValid}, 16'h0);
    step();                                                  // cycle 4
    checkOutput("lat_c4_resValid", {15'd0, resValid}, 16'h1);
    checkOutput("lat_c4_resO",     {4'd0, resO},      16'h0456);
    applyStimulus(mkCfg(1'b1, 4'd9, 3'b111, 2'b11), 8'h5A, 1'b0, 12'h456, 1'b1);
    step();
    applyStimulus(mkCfg(1'b1, 4'd9, 3'b111, 2'b11), 8'h5A, 1'b0, 12'h456, 1'b0);
    checkOutput("lat_txn", {8'd0, txnCount}, 16'h3);

    // ---------------- back-to-back LAT=0, wraps past 255 ----------------
    expTxn = 8'd3;
    applyStimulus(mkCfg(1'b1, 4'd0, 3'b111, 2'b11), 8'h5A, 1'b1, 12'h456, 1'b1);
    for (int i = 0; i < 256; i++) begin
      step();
      step();
      step();
      expTxn = expTxn + 8'd1;
      checkOutput("b2b_txn",     {8'd0, txnCount}, {8'd0, expTxn});
      checkOutput("b2b_opReady", {15'd0, opReady}, 16'h1);
    end
    applyStimulus(mkCfg(1'b1, 4'd0, 3'b111, 2'b11), 8'h5A, 1'b0, 12'h456, 1'b0);

    // ---------------- reset mid-WAIT ----------------
    applyStimulus(mkCfg(1'b1, 4'd10, 3'b111, 2'b11), 8'h5A, 1'b1, 12'h456, 1'b0);
    step();
    applyStimulus(mkCfg(1'b1, 4'd10, 3'b111, 2'b11), 8'h5A, 1'b0, 12'h456, 1'b0);
    step();
    step();
    step();
    checkOutput("mid_busy_before", {15'd0, busy}, 16'h1);
    rstN = 1'b0;
    #1;
    checkOutput("mid_rst_resValid", {15'd0, resValid}, 16'h0);
    checkOutput("mid_rst_opO",      {8'd0, opO},       16'h0);
    checkOutput("mid_rst_resO",     {4'd0, resO},      16'h0);
    checkOutput("mid_rst_txn",      {8'd0, txnCount},  16'h0);
    checkOutput("mid_rst_opReady",  {15'd0, opReady},  16'h0);
    checkOutput("mid_rst_busy",     {15'd0, busy},     16'h0);
    step();
    rstN = 1'b1;
    step();
    checkOutput("mid_rel_opReady",  {15'd0, opReady},  16'h1);
    checkOutput("mid_rel_busy",     {15'd0, busy},     16'h0);
    checkOutput("mid_rel_resValid", {15'd0, resValid}, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/cpu_io_pass_ctrl.md
Name: cpu_io_pass_ctrl

Overview:
- Parametrised successor to the fixed 4-bit operand/result pass BELs of the CPU IO tile.
- Carries NUM_OP operand channels (CPU -> fabric) and NUM_RES result channels (fabric -> CPU), each WIDTH bits wide.
- Each channel is configured as either combinational pass-through or registered.
- Adds a configurable-latency valid/ready transaction controller, so the CPU can issue an operand set and receive a result after a fixed fabric compute latency.

Parameters:
- WIDTH, 4, bits per channel.
- NUM_OP, 2, operand channels.
- NUM_RES, 3, result channels.
- LAT_BITS, 4, width of latency field; maximum latency is 2^LAT_BITS-1.
- CNT_W, 8, transaction counter width.
- NoConfigBits, NUM_OP+NUM_RES+LAT_BITS+1, config bits consumed from the tile ConfigMem.

Ports:
- UserCLK  in  1  fabric user clock; only clock.
- UserRSTn  in  1  reset, asynchronous, active-low.
- ConfigBits  in  NoConfigBits  static configuration from the tile ConfigMem.
- op_data  in  NUM_OP*WIDTH  CPU operand bus; channel i is bits [i*WIDTH +: WIDTH].
- op_valid  in  1  CPU offers operands.
- op_ready  out  1  block accepts operands.
- OP_O  out  NUM_OP*WIDTH  operands into the switch matrix.
- RES_I  in  NUM_RES*WIDTH  results from the switch matrix.
- RES_O  out  NUM_RES*WIDTH  results to the CPU.
- res_valid  out  1  result available.
- res_ready  in  1  CPU takes result.
- busy  out  1  transaction in flight (state != IDLE).
- txn_count  out  CNT_W  completed-transaction counter.

Behaviour:
- ConfigBits layout:
  - [NUM_OP-1:0]: OP_REG[i].
  - next NUM_RES bits: RES_REG[j].
  - next LAT_BITS bits: LAT.
  - MSB: HS_EN.
- Reset (UserRSTn low, asynchronous):
  - state=IDLE, latency counter=0, all operand/result registers=0, txn_count=0.
  - res_valid=0, busy=0, op_ready=0 while reset is asserted.
  - Deassertion takes effect at the next UserCLK edge.
- Operand channel i:
  - OP_REG=0: OP_O slice = op_data slice, combinational.
  - OP_REG=1: OP_O slice driven from a register. With HS_EN=1 the register loads on accept (op_valid && op_ready); with HS_EN=0 it loads every cycle.
- Result channel j:
  - RES_REG=0: RES_O slice = RES_I slice, combinational, independent of the FSM.
  - RES_REG=1: RES_O slice driven from a capture register. With HS_EN=1 it loads only on the capture event; with HS_EN=0 it loads every cycle.
- FSM with HS_EN=1:
  - IDLE: op_ready=1. On accept, load counter with LAT (LAT sampled only here) -> WAIT.
  - WAIT: op_ready=0, busy=1. If counter!=0, decrement. If counter==0, capture RES_I into the RES_REG=1 registers -> DONE.
  - DONE: res_valid=1, captured values held stable. On res_ready: txn_count+=1 and -> IDLE.
  - Latency: accept at edge t gives res_valid high from cycle t+2+LAT. LAT=0 gives 2 cycles; LAT=15 gives 17 cycles.
  - No overlap: a new accept is possible only in the cycle after the DONE handshake.
  - res_ready while not in DONE is ignored.
  - op_valid while not in IDLE is ignored; op_valid may be held and is taken once IDLE is re-entered.
- HS_EN=0, or HS_EN dropping to 0 mid-transaction:
  - FSM forced to IDLE on the next edge; res_valid=0; op_ready=1.
  - txn_count holds; in-flight transaction abandoned and not counted.
- LAT changes mid-transaction have no effect on the current transaction.
- txn_count wraps from 2^CNT_W-1 to 0.
- OP_REG and RES_REG changes take effect combinationally on the mux select; register contents are not cleared.

Test Plan:
- Reset mid-WAIT (LAT=10, assert UserRSTn low 3 cycles after accept) -> immediately res_valid=0, OP_O/RES_O registered slices=0, txn_count=0; after release op_ready=1, state IDLE.
- HS_EN=1, LAT=3, all REG=1, op_data=0x5A, RES_I=0x123 stable, accept at edge 0 -> op_ready low cycles 1-4, res_valid high from cycle 5, RES_O=0x123, OP_O=0x5A; res_ready at cycle 7 -> txn_count=1, op_ready=1 at cycle 8.
- LAT=0 back-to-back with op_valid and res_ready tied high -> one transaction completes every 3 cycles; txn_count increments each time and wraps 255 -> 0 on the 256th.
- RES_REG=0 on channel 1 only: RES_I changes while in DONE -> channel 1 of RES_O follows RES_I, channels 0 and 2 hold captured values.
- HS_EN cleared in DONE without res_ready -> next cycle res_valid=0, state IDLE, txn_count unchanged, registered channels track their inputs every cycle.
- LAT changed from 2 to 9 during WAIT -> res_valid still rises at accept+4.
